// File: rtl/phys_reg_free_list_if.sv
// Free-list port bundle between the rename/commit side and the physical
// register free list.
//   master : rename/commit side; drives allocation requests and tag returns
//   slave  : free list; presents the head tag, occupancy and the error flag
// Signals:
//   alloc_req              rename consumes one tag this cycle
//   alloc_ready/alloc_preg list non-empty / tag at the head
//   free_valid/free_preg   commit returns a superseded tag
//   flush_valid/flush_preg flush walkback returns a squashed tag
//   free_count             number of free entries
//   err                    sticky protocol-violation flag
interface phys_reg_free_list_if #(
   parameter int unsigned PTAG_W = 6
) ();
   logic              alloc_req;
   logic              alloc_ready;
   logic [PTAG_W-1:0] alloc_preg;
   logic              free_valid;
   logic [PTAG_W-1:0] free_preg;
   logic              flush_valid;
   logic [PTAG_W-1:0] flush_preg;
   logic [PTAG_W:0]   free_count;
   logic              err;

   modport master (
      output alloc_req, free_valid, free_preg, flush_valid, flush_preg,
      input  alloc_ready, alloc_preg, free_count, err
   );

   modport slave (
      input  alloc_req, free_valid, free_preg, flush_valid, flush_preg,
      output alloc_ready, alloc_preg, free_count, err
   );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags. Hands the head tag to rename,
// accepts superseded tags from commit and squashed tags from flush walkback.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    phys_reg_free_list_if.slave (alloc / free / flush / status)
// Optional feature: define FREE_LIST_CHECK_EN to track an is_free vector and
// reject double frees.
module phys_reg_free_list #(
   parameter int unsigned NUM_PHYS = 64,
   parameter int unsigned NUM_ARCH = 32,
   parameter int unsigned PTAG_W   = 6
) (
   input logic                 clk,
   input logic                 rst_n,
   phys_reg_free_list_if.slave bus
);

   typedef logic [PTAG_W-1:0] ptag_t;
   typedef logic [PTAG_W:0]   cnt_t;
   // One bit wider than the count so NUM_PHYS + 1 is representable.
   typedef logic [PTAG_W+1:0] cnt_ext_t;

   localparam cnt_ext_t NumPhysX = cnt_ext_t'(NUM_PHYS);

   ptag_t mem_q [NUM_PHYS];
   ptag_t head_q, head_d;
   ptag_t tail_q, tail_d;
   cnt_t  count_q, count_d;
   logic  err_q, err_d;

   logic  pop, underflow;
   logic  free_ok, flush_ok;
   logic  free_fit, flush_fit;
   logic  free_acc, flush_acc;
   logic  drop;
   ptag_t flush_ptr;

`ifdef FREE_LIST_CHECK_EN
   logic [NUM_PHYS-1:0] is_free_q, is_free_d;

   always_comb begin
      free_ok  = !is_free_q[bus.free_preg];
      // A flush of the same tag as this cycle's free is a duplicate.
      flush_ok = !is_free_q[bus.flush_preg] &&
                 !(bus.free_valid && (bus.free_preg == bus.flush_preg));
   end

   always_comb begin
      is_free_d = is_free_q;
      if (pop)       is_free_d[mem_q[head_q]] = 1'b0;
      if (free_acc)  is_free_d[bus.free_preg] = 1'b1;
      if (flush_acc) is_free_d[bus.flush_preg] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_PHYS; i++) begin
            is_free_q[i] <= (i >= NUM_ARCH);
         end
      end else begin
         is_free_q <= is_free_d;
      end
   end
`else
   always_comb begin
      free_ok  = 1'b1;
      flush_ok = 1'b1;
   end
`endif

   always_comb begin
      pop       = bus.alloc_req && (count_q != '0);
      underflow = bus.alloc_req && (count_q == '0);
      // A same-cycle pop frees a slot, so pushes on a full list remain legal.
      free_fit  = (cnt_ext_t'(count_q) + cnt_ext_t'(1)) <= (NumPhysX + cnt_ext_t'(pop));
      free_acc  = bus.free_valid && free_ok && free_fit;
      flush_fit = (cnt_ext_t'(count_q) + cnt_ext_t'(free_acc) + cnt_ext_t'(1)) <=
                  (NumPhysX + cnt_ext_t'(pop));
      flush_acc = bus.flush_valid && flush_ok && flush_fit;
      drop      = (bus.free_valid && !free_acc) || (bus.flush_valid && !flush_acc);

      flush_ptr = tail_q + ptag_t'(free_acc);
      head_d    = pop ? head_q + ptag_t'(1) : head_q;
      tail_d    = tail_q + ptag_t'(free_acc) + ptag_t'(flush_acc);
      count_d   = count_q + cnt_t'(free_acc) + cnt_t'(flush_acc) - cnt_t'(pop);
      err_d     = err_q | underflow | drop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= ptag_t'(NUM_PHYS - NUM_ARCH);
         count_q <= cnt_t'(NUM_PHYS - NUM_ARCH);
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_PHYS; i++) begin
            mem_q[i] <= (i < NUM_PHYS - NUM_ARCH) ? ptag_t'(NUM_ARCH + i) : '0;
         end
      end else begin
         if (free_acc)  mem_q[tail_q]    <= bus.free_preg;
         if (flush_acc) mem_q[flush_ptr] <= bus.flush_preg;
      end
   end

   assign bus.alloc_ready = (count_q != '0);
   assign bus.alloc_preg  = mem_q[head_q];
   assign bus.free_count  = count_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboarded bench for phys_reg_free_list: a queue-based reference model
// predicts the visible state each cycle; a monitor compares mid-cycle.
module tb_phys_reg_free_list;

   localparam int NUM_PHYS = 64;
   localparam int NUM_ARCH = 32;
   localparam int PTAG_W   = 6;
`ifdef FREE_LIST_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct {
      bit ready;
      int tag;
      int cnt;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   phys_reg_free_list_if #(.PTAG_W(PTAG_W)) bus ();

   phys_reg_free_list #(
      .NUM_PHYS(NUM_PHYS),
      .NUM_ARCH(NUM_ARCH),
      .PTAG_W  (PTAG_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: the free list is simply an ordered queue of tags.
   int            m_q[$];
   bit            m_err;
   bit [NUM_PHYS-1:0] m_free;
   exp_t          exp_q[$];

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      for (int i = NUM_ARCH; i < NUM_PHYS; i++) m_q.push_back(i);
      m_err  = 1'b0;
      m_free = '0;
      for (int i = NUM_ARCH; i < NUM_PHYS; i++) m_free[i] = 1'b1;
   endtask

   task automatic model_step(input bit req, input bit fv, input int fp,
                             input bit flv, input int flp, output exp_t e);
      bit pop, f_acc, fl_acc, dup;
      int room, t;
      e.ready = (m_q.size() != 0);
      e.tag   = (m_q.size() != 0) ? m_q[0] : 0;
      e.cnt   = m_q.size();
      e.err   = m_err;
      pop = req && (m_q.size() != 0);
      if (req && !pop) m_err = 1'b1;
      room   = NUM_PHYS - m_q.size() + (pop ? 1 : 0);
      f_acc  = 1'b0;
      fl_acc = 1'b0;
      if (fv) begin
         dup = CHK && m_free[fp];
         if (!dup && room > 0) begin
            f_acc = 1'b1;
            room--;
         end else m_err = 1'b1;
      end
      if (flv) begin
         dup = CHK && (m_free[flp] || (fv && fp == flp));
         if (!dup && room > 0) fl_acc = 1'b1;
         else m_err = 1'b1;
      end
      if (pop) begin
         t = m_q.pop_front();
         m_free[t] = 1'b0;
      end
      if (f_acc) begin
         m_q.push_back(fp);
         m_free[fp] = 1'b1;
      end
      if (fl_acc) begin
         m_q.push_back(flp);
         m_free[flp] = 1'b1;
      end
   endtask

   // One clock edge worth of stimulus; the expected visible state for this
   // cycle goes to the scoreboard.
   task automatic cycle(input bit req, input bit fv, input int fp,
                        input bit flv, input int flp);
      exp_t e;
      @(posedge clk);
      #1;
      bus.alloc_req   = req;
      bus.free_valid  = fv;
      bus.free_preg   = PTAG_W'(fp);
      bus.flush_valid = flv;
      bus.flush_preg  = PTAG_W'(flp);
      model_step(req, fv, fp, flv, flp, e);
      exp_q.push_back(e);
   endtask

   task automatic idle();
      bus.alloc_req   = 1'b0;
      bus.free_valid  = 1'b0;
      bus.free_preg   = '0;
      bus.flush_valid = 1'b0;
      bus.flush_preg  = '0;
   endtask

   // Asserts reset between clock edges and checks outputs before any edge.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check("rst_alloc_ready", int'(bus.alloc_ready), 1);
      check("rst_alloc_preg", int'(bus.alloc_preg), NUM_ARCH);
      check("rst_free_count", int'(bus.free_count), NUM_PHYS - NUM_ARCH);
      check("rst_err", int'(bus.err), 0);
      idle();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Monitor: compares DUT-presented state against the scoreboard mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("alloc_ready", int'(bus.alloc_ready), int'(e.ready));
            check("free_count", int'(bus.free_count), e.cnt);
            check("err", int'(bus.err), int'(e.err));
            if (e.ready) check("alloc_preg", int'(bus.alloc_preg), e.tag);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      do_reset();

      // Drain the initial 32 free tags, then one pop on empty.
      repeat (32) cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      // Empty list: both returns in one cycle, then pop them in order.
      cycle(0, 1, 5, 1, 9);
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Steady alloc+free wraps the pointers without changing occupancy.
      do_reset();
      repeat (40) cycle(1, 1, 7, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Overflow: fill from 32 up past 64 with double pushes.
      do_reset();
      repeat (18) cycle(0, 1, $urandom_range(0, 31), 1, $urandom_range(0, 31));
      cycle(0, 0, 0, 0, 0);

`ifdef FREE_LIST_CHECK_EN
      do_reset();
      cycle(0, 1, 40, 0, 0);
      cycle(0, 0, 0, 0, 0);
`endif

      // Randomized traffic, a fresh reset per phase so err is exercised anew.
      for (int p = 0; p < 3; p++) begin
         do_reset();
         repeat (250) begin
            cycle($urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 35, $urandom_range(0, NUM_PHYS - 1),
                  $urandom_range(0, 99) < 15, $urandom_range(0, NUM_PHYS - 1));
         end
      end

      // Mid-sequence asynchronous reset, then first allocation yields 32.
      do_reset();
      repeat (10) cycle(1, 0, 0, 0, 0);
      do_reset();
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      @(posedge clk);
      #6;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
